pattern_serializer: RTL

- Parallel-to-serial stage directly upstream of the sequence-detector FSM.
- Accepts a WIDTH-bit test word through a valid/ready handshake and shifts it out one bit per clock on ser_out, which drives the detector's `in` port.
- Provides a `ser_valid` qualifier, a stall input and a completion pulse, so pattern and non-pattern streams can be replayed without hand-driving each bit.

---
 rtl/pattern_serializer.sv | 59 +++++
 1 files changed

// File: rtl/pattern_serializer.sv
// pattern_serializer: loads a word through valid/ready and shifts it out one bit per clock toward the sequence detector
module pattern_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1
) (
    input  logic                       flux,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           load_data,
    input  logic                       load_valid,
    output logic                       load_ready,
    input  logic                       stall,
    output logic                       ser_out,
    output logic                       ser_valid,
    output logic [$clog2(WIDTH+1)-1:0] bits_left,
    output logic                       done
);
    localparam int BW = $clog2(WIDTH+1);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] sreg, sreg_n;
    logic [BW-1:0] cnt, cnt_n;
    logic accept;
    assign load_ready = state != SHIFT;
    assign accept     = load_valid && load_ready;
    assign ser_valid  = state == SHIFT;
    assign done       = state == DONE;
    assign bits_left  = cnt;
    // the shifter zero-fills, so the output bit is already 0 once the word is drained
    assign ser_out    = ser_valid && (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]);
    always_comb begin
        state_n = state;
        sreg_n  = sreg;
        cnt_n   = cnt;
        if (state == SHIFT) begin
            if (!stall) begin
                sreg_n  = MSB_FIRST ? sreg << 1 : sreg >> 1;
                cnt_n   = cnt - BW'(1);
                state_n = cnt == BW'(1) ? DONE : SHIFT;
            end
        end else if (accept) begin
            sreg_n  = load_data;
            cnt_n   = BW'(WIDTH);
            state_n = SHIFT;
        end else if (state == DONE) begin
            state_n = IDLE;
        end
    end
    always_ff @(posedge flux) begin
        if (!reset) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            sreg  <= sreg_n;
            cnt   <= cnt_n;
        end
    end
endmodule
